// File: rtl/hazard_stall_controller.sv
// Hazard stall controller for the ID stage.
// Generates stall/bubble/flush controls for load-use, branch squash and
// HI/LO unit occupancy, owns the MULT/DIV issue handshake and latency
// counter, and keeps a saturating count of stall cycles.
module hazard_stall_controller #(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 32,
  parameter int CNT_W       = 6,
  parameter int STALLCNT_W  = 16
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [4:0]            ID_Rs,
  input  logic [4:0]            ID_Rt,
  input  logic                  ID_UsesRs,
  input  logic                  ID_UsesRt,
  input  logic                  ID_IsMulDiv,
  input  logic                  ID_IsDiv,
  input  logic                  ID_ReadsHiLo,
  input  logic                  EX_MemRead,
  input  logic [4:0]            EX_Rw,
  input  logic                  EX_BranchTaken,
  output logic                  PCWrite,
  output logic                  IFID_Write,
  output logic                  IFID_Flush,
  output logic                  IDEX_Bubble,
  output logic                  MulDivStart,
  output logic                  MulDivIsDiv,
  output logic                  MulDivBusy,
  output logic [STALLCNT_W-1:0] StallCycles
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] MUL_LAT_C = CNT_W'(MUL_LATENCY);
  localparam logic [CNT_W-1:0] DIV_LAT_C = CNT_W'(DIV_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  start_q, start_d;
  logic                  isdiv_q, isdiv_d;
  logic [STALLCNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic hilo_hazard;
  logic stall;
  logic issue;
  logic busy;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [STALLCNT_W-1:0] sat_inc(input logic [STALLCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign busy = (state_q == S_BUSY);

  // Hazard detection; $0 is never a real producer so it cannot cause load-use.
  always_comb begin
    load_use    = EX_MemRead && (EX_Rw != 5'd0) &&
                  ((ID_UsesRs && (ID_Rs == EX_Rw)) || (ID_UsesRt && (ID_Rt == EX_Rw)));
    hilo_hazard = (ID_ReadsHiLo || ID_IsMulDiv) && busy;
    stall       = (load_use || hilo_hazard) && !EX_BranchTaken;
    issue       = ID_IsMulDiv && !stall && !EX_BranchTaken;
  end

  // Pipeline control outputs; a taken branch overrides any stall.
  always_comb begin
    PCWrite     = !stall;
    IFID_Write  = !stall;
    IFID_Flush  = EX_BranchTaken;
    IDEX_Bubble = stall || EX_BranchTaken;
  end

  assign MulDivBusy  = busy;
  assign MulDivStart = start_q;
  assign MulDivIsDiv = isdiv_q;
  assign StallCycles = stall_cnt_q;

  // Issue FSM and latency counter; busy lasts exactly the loaded latency.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    start_d     = 1'b0;
    isdiv_d     = isdiv_q;
    stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d = S_BUSY;
          cnt_d   = ID_IsDiv ? DIV_LAT_C : MUL_LAT_C;
          start_d = 1'b1;
          isdiv_d = ID_IsDiv;
        end
      end
      S_BUSY: begin
        if (cnt_q == CNT_ONE_C) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      isdiv_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      isdiv_q     <= isdiv_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Testbench for hazard_stall_controller: directed scenarios followed by
// random traffic, all checked against a cycle-indexed behavioural model.
module tb_hazard_stall_controller;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
  localparam int SCW     = 6;
  localparam int SMAX    = (1 << SCW) - 1;

  logic           CLK = 1'b0;
  logic           Reset;
  logic [4:0]     ID_Rs, ID_Rt, EX_Rw;
  logic           ID_UsesRs, ID_UsesRt, ID_IsMulDiv, ID_IsDiv, ID_ReadsHiLo;
  logic           EX_MemRead, EX_BranchTaken;
  logic           PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble;
  logic           MulDivStart, MulDivIsDiv, MulDivBusy;
  logic [SCW-1:0] StallCycles;

  int checks   = 0;
  int failures = 0;

  // Model state: cycle index, first idle cycle of the HI/LO unit, cycle of
  // the start pulse and its op, and the stall count.
  int cyc       = 0;
  int free_cyc  = 0;
  int start_cyc = -1;
  bit start_div = 1'b0;
  int stall_cnt = 0;
  bit chk_en    = 1'b0;

  hazard_stall_controller #(
    .MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT), .CNT_W(6), .STALLCNT_W(SCW)
  ) dut (
    .CLK(CLK), .Reset(Reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_IsMulDiv(ID_IsMulDiv), .ID_IsDiv(ID_IsDiv), .ID_ReadsHiLo(ID_ReadsHiLo),
    .EX_MemRead(EX_MemRead), .EX_Rw(EX_Rw), .EX_BranchTaken(EX_BranchTaken),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Bubble(IDEX_Bubble), .MulDivStart(MulDivStart), .MulDivIsDiv(MulDivIsDiv),
    .MulDivBusy(MulDivBusy), .StallCycles(StallCycles)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
    ID_IsMulDiv = 1'b0; ID_IsDiv = 1'b0; ID_ReadsHiLo = 1'b0;
    EX_MemRead = 1'b0; EX_Rw = 5'd0; EX_BranchTaken = 1'b0; Reset = 1'b0;
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then let
  // the model take the same edge the DUT takes.
  task automatic step();
    bit busy, lu, hh, st, iss;
    @(negedge CLK);
    busy = (cyc < free_cyc);
    lu   = EX_MemRead && (EX_Rw != 5'd0) &&
           ((ID_UsesRs && ID_Rs == EX_Rw) || (ID_UsesRt && ID_Rt == EX_Rw));
    hh   = (ID_ReadsHiLo || ID_IsMulDiv) && busy;
    st   = (lu || hh) && !EX_BranchTaken;
    iss  = ID_IsMulDiv && !st && !EX_BranchTaken;
    if (chk_en) begin
      check("PCWrite",     32'(PCWrite),     32'(!st));
      check("IFID_Write",  32'(IFID_Write),  32'(!st));
      check("IFID_Flush",  32'(IFID_Flush),  32'(EX_BranchTaken));
      check("IDEX_Bubble", 32'(IDEX_Bubble), 32'(st || EX_BranchTaken));
      check("MulDivBusy",  32'(MulDivBusy),  32'(busy));
      check("MulDivStart", 32'(MulDivStart), 32'(cyc == start_cyc));
      if (cyc == start_cyc) check("MulDivIsDiv", 32'(MulDivIsDiv), 32'(start_div));
      check("StallCycles", 32'(StallCycles), 32'(stall_cnt));
    end
    @(posedge CLK);
    if (Reset) begin
      free_cyc = 0; start_cyc = -1; start_div = 1'b0; stall_cnt = 0;
    end else begin
      if (st && stall_cnt < SMAX) stall_cnt++;
      if (iss) begin
        start_cyc = cyc + 1;
        start_div = ID_IsDiv;
        free_cyc  = cyc + 1 + (ID_IsDiv ? DIV_LAT : MUL_LAT);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    Reset = 1'b1;
    step();
    step();
    chk_en = 1'b1;
    idle_inputs();

    // Reset state
    check("rst_start", 32'(MulDivStart), 32'(0));
    check("rst_isdiv", 32'(MulDivIsDiv), 32'(0));
    check("rst_busy",  32'(MulDivBusy),  32'(0));
    check("rst_cnt",   32'(StallCycles), 32'(0));
    check("rst_pcw",   32'(PCWrite),     32'(1));
    step();

    // Load-use on rs: one stall, then forwarding covers it
    do_reset();
    EX_MemRead = 1'b1; EX_Rw = 5'd5; ID_Rs = 5'd5; ID_UsesRs = 1'b1;
    step();
    check("lu_cnt", 32'(StallCycles), 32'(1));
    EX_MemRead = 1'b0; EX_Rw = 5'd0;
    step();
    check("lu_release_cnt", 32'(StallCycles), 32'(1));

    // Load to $0 never stalls
    do_reset();
    EX_MemRead = 1'b1; EX_Rw = 5'd0; ID_Rs = 5'd0; ID_UsesRs = 1'b1;
    ID_Rt = 5'd0; ID_UsesRt = 1'b1;
    step(); step();
    check("r0_cnt", 32'(StallCycles), 32'(0));

    // MULT then MFLO: four stall cycles
    do_reset();
    ID_IsMulDiv = 1'b1;
    step();
    ID_IsMulDiv = 1'b0; ID_ReadsHiLo = 1'b1;
    repeat (5) step();
    check("mult_mflo_cnt", 32'(StallCycles), 32'(4));
    idle_inputs();
    step();

    // DIV followed by MULT: 32 stall cycles, then a MULT start
    do_reset();
    ID_IsMulDiv = 1'b1; ID_IsDiv = 1'b1;
    step();
    ID_IsDiv = 1'b0;
    repeat (33) step();
    check("div_mult_cnt", 32'(StallCycles), 32'(32));
    idle_inputs();
    check("div_mult_start", 32'(MulDivStart), 32'(1));
    check("div_mult_isdiv", 32'(MulDivIsDiv), 32'(0));
    repeat (5) step();

    // Branch beats load-use and squashes a MULT
    do_reset();
    EX_MemRead = 1'b1; EX_Rw = 5'd7; ID_Rs = 5'd7; ID_UsesRs = 1'b1;
    ID_IsMulDiv = 1'b1; EX_BranchTaken = 1'b1;
    step();
    idle_inputs();
    check("br_nostart", 32'(MulDivStart), 32'(0));
    check("br_cnt",     32'(StallCycles), 32'(0));
    step();

    // Branch during DIV does not abort it
    ID_IsMulDiv = 1'b1; ID_IsDiv = 1'b1;
    step();
    idle_inputs();
    EX_BranchTaken = 1'b1;
    repeat (3) step();
    check("br_busy_kept", 32'(MulDivBusy), 32'(1));
    idle_inputs();

    // Reset with the DIV counter at 17 and an MFHI waiting
    do_reset();
    ID_IsMulDiv = 1'b1; ID_IsDiv = 1'b1;
    step();
    idle_inputs();
    repeat (15) step();
    ID_ReadsHiLo = 1'b1; Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("rstdiv_busy", 32'(MulDivBusy), 32'(0));
    check("rstdiv_pcw",  32'(PCWrite),    32'(1));
    step();
    check("rstdiv_cnt",  32'(StallCycles), 32'(0));

    // Stall counter saturation
    do_reset();
    EX_MemRead = 1'b1; EX_Rw = 5'd3; ID_Rt = 5'd3; ID_UsesRt = 1'b1;
    repeat (SMAX + 6) step();
    check("sat_cnt", 32'(StallCycles), 32'(SMAX));
    idle_inputs();

    // Random traffic on a small register set to provoke collisions
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ID_Rs          = 5'($urandom_range(0, 3));
      ID_Rt          = 5'($urandom_range(0, 3));
      ID_UsesRs      = 1'($urandom_range(0, 1));
      ID_UsesRt      = 1'($urandom_range(0, 1));
      ID_IsMulDiv    = ($urandom_range(0, 5) == 0);
      ID_IsDiv       = ($urandom_range(0, 3) == 0);
      ID_ReadsHiLo   = ($urandom_range(0, 5) == 0);
      EX_MemRead     = ($urandom_range(0, 2) == 0);
      EX_Rw          = 5'($urandom_range(0, 3));
      EX_BranchTaken = ($urandom_range(0, 9) == 0);
      Reset          = ($urandom_range(0, 299) == 0);
      step();
    end
    idle_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
